// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the program/data memory arbiter: FSM state
//   encoding, requester port indices and the address/word width defaults
//   used by the memory and the processor.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_WORD_W = 16;

    // Requester port indices.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Index of the port that is not p.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational two-way round-robin selector.
//   Ports:
//     req0, req1 : pending requests
//     last       : index of the port that owned the memory most recently
//     winner     : selected port index (only meaningful when a request exists)
//   On a tie the port that did not own last wins; a lone request always wins.
module rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = other_port(last);
        end else if (req1) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port program/data memory between the CPU control unit
//   (port 0) and the program loader/debug port (port 1). Ownership persists
//   across back-to-back accesses, is capped by MAX_BURST while the other port
//   waits, and ties are broken round-robin.
//   Ports:
//     clk, rst                : clock, asynchronous active-low reset
//     reqK, weK, addrK, wdataK: requester K access (K = 0, 1)
//     gntK                    : access performed this cycle
//     rvalidK, rdataK         : registered read return, one cycle after gntK
//     owner, busy             : current owner index, state != IDLE
//     mem_addr/wdata/write    : memory drive, mem_rdata combinational read
//     dbg_state, dbg_burst_cnt, dbg_last : internal FSM state for observation
//
//   Handshake: a requester raises reqK with weK/addrK/wdataK and holds all of
//   them stable until a rising edge at which gntK=1; that edge performs the
//   access. gntK is combinational from the registered state and reqK, so the
//   requester may change its inputs in the cycle after the granting edge.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0,
    input  logic                           req1,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [ADDR_W-1:0]              addr0,
    input  logic [ADDR_W-1:0]              addr1,
    input  logic [WORD_W-1:0]              wdata0,
    input  logic [WORD_W-1:0]              wdata1,
    output logic                           gnt0,
    output logic                           gnt1,
    output logic                           rvalid0,
    output logic                           rvalid1,
    output logic [WORD_W-1:0]              rdata0,
    output logic [WORD_W-1:0]              rdata1,
    output logic                           owner,
    output logic                           busy,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [WORD_W-1:0]              mem_wdata,
    output logic                           mem_write,
    input  logic [WORD_W-1:0]              mem_rdata,
    output arb_state_t                     dbg_state,
    output logic [$clog2(MAX_BURST+1)-1:0] dbg_burst_cnt,
    output logic                           dbg_last
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;
    logic             pick;
    logic             cap_hit;

    rr_pick u_rr_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (pick)
    );

    // Grants follow the registered owner and that owner's live request.
    assign gnt0 = (state == ST_OWN0) && req0;
    assign gnt1 = (state == ST_OWN1) && req1;

    // Port 0 is the default mux leg, so addr/wdata show port 0 when idle.
    assign mem_addr  = gnt1 ? addr1  : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign mem_write = (gnt0 && we0) || (gnt1 && we1);

    assign owner = (state == ST_OWN1);
    assign busy  = (state != ST_IDLE);

    assign dbg_state     = state;
    assign dbg_burst_cnt = burst_cnt;
    assign dbg_last      = last;

    // The counter saturates at MAX_BURST, so ">=" keeps the cap effective
    // when the other port starts requesting only after saturation.
    assign cap_hit = (burst_cnt >= CNT_LAST);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    next_state = (pick == PORT_LDR) ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    next_state = req1 ? ST_OWN1 : ST_IDLE;
                end else if (req1 && cap_hit) begin
                    next_state = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    next_state = req0 ? ST_OWN0 : ST_IDLE;
                end else if (req0 && cap_hit) begin
                    next_state = ST_OWN0;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            last      <= PORT_LDR;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                burst_cnt <= '0;
                // Leaving IDLE has no previous owner, so last is kept.
                if (state != ST_IDLE) begin
                    last <= (state == ST_OWN1);
                end
            end else if ((gnt0 || gnt1) && (burst_cnt != CNT_MAX)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0 <= mem_rdata;
            end
            if (gnt1 && !we1) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_write, dbg_last;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic [2:0]  dbg_burst_cnt;
  arb_state_t  dbg_state;

  logic [15:0] mem [0:255];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(12), .WORD_W(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .owner(owner), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt), .dbg_last(dbg_last)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] = mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_async_mem_write: got %0b want 0", mem_write); end
    do_reset();
    #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    checks++; if (dbg_last !== 1'b1) begin errors++; $display("FAIL rst_last: got %0b want 1", dbg_last); end
    checks++; if (dbg_burst_cnt !== 3'd0) begin errors++; $display("FAIL rst_burst_cnt: got %0d want 0", dbg_burst_cnt); end
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_write} !== 7'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 0000000", {gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_write}); end
    checks++; if ({rdata0, rdata1} !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {rdata0, rdata1}); end
  endtask

  task automatic test_single_read();
    mem[8'h05] = 16'h1234;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
    #1;
    checks++; if (gnt0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sr_idle: gnt0=%0b busy=%0b want 0 0", gnt0, busy); end
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL sr_gnt0: got %0b want 1", gnt0); end
    checks++; if (busy !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL sr_busy_owner: busy=%0b owner=%0b want 1 0", busy, owner); end
    checks++; if (mem_addr !== 12'h005 || mem_write !== 1'b0) begin errors++; $display("FAIL sr_mem_drive: addr=%h write=%0b want 005 0", mem_addr, mem_write); end
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'h1234) begin errors++; $display("FAIL sr_rdata: rvalid0=%0b rdata0=%h want 1 1234", rvalid0, rdata0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL sr_rvalid1: got %0b want 0", rvalid1); end
    req0 = 1'b0;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL sr_release: gnt0=%0b want 0", gnt0); end
    tick();
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h1234) begin errors++; $display("FAIL sr_pulse_hold: rvalid0=%0b rdata0=%h want 0 1234", rvalid0, rdata0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_back_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_tie();
    do_reset();
    mem[8'h10] = 16'h1010; mem[8'h20] = 16'h2020;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL tie_first: gnt0=%0b gnt1=%0b want 1 0", gnt0, gnt1); end
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'h1010) begin errors++; $display("FAIL tie_rdata0: rvalid0=%0b rdata0=%h want 1 1010", rvalid0, rdata0); end
    req0 = 1'b0;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tie_dead: gnt0=%0b gnt1=%0b busy=%0b want 0 0 1", gnt0, gnt1, busy); end
    tick();
    checks++; if (gnt1 !== 1'b1 || owner !== 1'b1 || dbg_last !== 1'b0) begin errors++; $display("FAIL tie_switch: gnt1=%0b owner=%0b last=%0b want 1 1 0", gnt1, owner, dbg_last); end
    tick();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 16'h2020) begin errors++; $display("FAIL tie_rdata1: rvalid1=%0b rdata1=%h want 1 2020", rvalid1, rdata1); end
    req1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || dbg_last !== 1'b1) begin errors++; $display("FAIL tie_idle_last: busy=%0b last=%0b want 0 1", busy, dbg_last); end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL tie_second: gnt0=%0b gnt1=%0b want 1 0", gnt0, gnt1); end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_burst_cap();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h002;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || dbg_burst_cnt !== 3'(i)) begin errors++; $display("FAIL burst_gnt0_%0d: gnt0=%0b gnt1=%0b cnt=%0d want 1 0 %0d", i, gnt0, gnt1, dbg_burst_cnt, i); end
      tick();
    end
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || dbg_burst_cnt !== 3'd0) begin errors++; $display("FAIL burst_forced: gnt1=%0b gnt0=%0b cnt=%0d want 1 0 0", gnt1, gnt0, dbg_burst_cnt); end
    tick();
    req1 = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (gnt0 !== 1'b1 || dbg_burst_cnt !== 3'd4) begin errors++; $display("FAIL burst_saturate: gnt0=%0b cnt=%0d want 1 4", gnt0, dbg_burst_cnt); end
    req0 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || dbg_burst_cnt !== 3'd0) begin errors++; $display("FAIL burst_idle: busy=%0b cnt=%0d want 0 0", busy, dbg_burst_cnt); end
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0FF; wdata1 = 16'hBEEF;
    tick();
    checks++; if (gnt1 !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_grant: gnt1=%0b mem_write=%0b want 1 1", gnt1, mem_write); end
    checks++; if (mem_addr !== 12'h0FF || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_drive: addr=%h wdata=%h want 0ff beef", mem_addr, mem_wdata); end
    tick();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %0b want 0", rvalid1); end
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0FF;
    #1;
    checks++; if (mem_write !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: mem_write=%0b gnt0=%0b want 0 0", mem_write, gnt0); end
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt0: got %0b want 1", gnt0); end
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_data: rvalid0=%0b rdata0=%h want 1 beef", rvalid0, rdata0); end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h030; wdata1 = 16'hAAAA;
    tick();
    checks++; if (mem_write !== 1'b1 || gnt1 !== 1'b1) begin errors++; $display("FAIL rm_pre: mem_write=%0b gnt1=%0b want 1 1", mem_write, gnt1); end
    rst = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: mem_write=%0b gnt1=%0b busy=%0b want 0 0 0", mem_write, gnt1, busy); end
    checks++; if (rdata0 !== 16'h0) begin errors++; $display("FAIL rm_rdata0: got %h want 0", rdata0); end
    req1 = 1'b0; we1 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (dbg_state !== ST_IDLE || dbg_last !== 1'b1 || dbg_burst_cnt !== 3'd0) begin errors++; $display("FAIL rm_state: state=%0d last=%0b cnt=%0d want 0 1 0", dbg_state, dbg_last, dbg_burst_cnt); end
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_write} !== 7'b0) begin errors++; $display("FAIL rm_outputs: got %b want 0000000", {gnt0, gnt1, rvalid0, rvalid1, owner, busy, mem_write}); end
    checks++; if (mem[8'h30] !== 16'h0) begin errors++; $display("FAIL rm_no_commit: mem[30]=%h want 0", mem[8'h30]); end
  endtask

  task automatic test_stress();
    logic g0, g1;
    g0 = 1'b0; g1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!req0 || g0) begin
        req0 = ($urandom_range(0, 9) < 7); we0 = 1'($urandom_range(0, 1));
        addr0 = 12'($urandom_range(0, 255)); wdata0 = 16'($urandom_range(0, 65535));
      end
      if (!req1 || g1) begin
        req1 = ($urandom_range(0, 9) < 7); we1 = 1'($urandom_range(0, 1));
        addr1 = 12'($urandom_range(0, 255)); wdata1 = 16'($urandom_range(0, 65535));
      end
      #1;
      g0 = gnt0; g1 = gnt1;
      checks++; if (g0 && g1) begin errors++; $display("FAIL st_both_gnt cyc %0d: gnt0=%0b gnt1=%0b", cyc, g0, g1); end
      checks++; if (mem_write !== ((g0 && we0) || (g1 && we1))) begin errors++; $display("FAIL st_mem_write cyc %0d: got %0b want %0b", cyc, mem_write, (g0 && we0) || (g1 && we1)); end
      if (g0 && !we0) exp_q0.push_back(mem[addr0[7:0]]);
      if (g1 && !we1) exp_q1.push_back(mem[addr1[7:0]]);
      tick();
      checks++; if (rvalid0 !== (exp_q0.size() != 0)) begin errors++; $display("FAIL st_rvalid0 cyc %0d: got %0b want %0b", cyc, rvalid0, exp_q0.size() != 0); end
      if (exp_q0.size() != 0) begin
        logic [15:0] e0;
        e0 = exp_q0.pop_front();
        checks++; if (rdata0 !== e0) begin errors++; $display("FAIL st_rdata0 cyc %0d: got %h want %h", cyc, rdata0, e0); end
      end
      checks++; if (rvalid1 !== (exp_q1.size() != 0)) begin errors++; $display("FAIL st_rvalid1 cyc %0d: got %0b want %0b", cyc, rvalid1, exp_q1.size() != 0); end
      if (exp_q1.size() != 0) begin
        logic [15:0] e1;
        e1 = exp_q1.pop_front();
        checks++; if (rdata1 !== e1) begin errors++; $display("FAIL st_rdata1 cyc %0d: got %h want %h", cyc, rdata1, e1); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_single_read();
    test_tie();
    test_burst_cap();
    test_write_read();
    test_reset_mid();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port 256×16 program/data memory between the CPU control unit (port 0) and a program loader/debug port (port 1). It sits between the requesters and the memory: it drives the memory address, write data and write strobe, and returns registered read data to the port that owns the memory. Ownership persists across back-to-back accesses, is capped by a burst limit, and ties are broken round-robin.

## Interface
- `ADDR_W`, 12: address width; matches the memory address port.
- `WORD_W`, 16: data word width.
- `MAX_BURST`, 4: maximum consecutive grants to one port while the other port is requesting; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: access request; held until granted.
- `we0`, `we1` in 1: 1 = write, 0 = read; qualifies `req`.
- `addr0`, `addr1` in `ADDR_W`: access address.
- `wdata0`, `wdata1` in `WORD_W`: write data.
- `gnt0`, `gnt1` out 1: access performed this cycle.
- `rvalid0`, `rvalid1` out 1: read data valid, one cycle after a granted read.
- `rdata0`, `rdata1` out `WORD_W`: registered read data.
- `owner` out 1: current owner index; meaningful only when `busy`=1.
- `busy` out 1: state ≠ IDLE.
- `mem_addr` out `ADDR_W`, `mem_wdata` out `WORD_W`, `mem_write` out 1: memory drive.
- `mem_rdata` in `WORD_W`: memory combinational read data.

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: no grant and `mem_write`=0. If only `reqk` is high, next state is OWNk. If both are high, next state is OWN of the port ≠ `last`. If neither is high, stay in IDLE.
- OWNk with `reqk`=1: `gntk`=1 and the memory is driven combinationally from port k (`mem_addr`=`addrk`, `mem_wdata`=`wdatak`, `mem_write`=`wek`). `burst_cnt` increments, saturating at `MAX_BURST`.
- OWNk with `reqk`=0: no access. Next state is OWN(other) if the other port is requesting, otherwise IDLE.
- Forced switch: when a grant occurs with `burst_cnt`=`MAX_BURST`−1 and the other port is requesting, next state is OWN(other) even if `reqk` stays high.
- On every state change: `burst_cnt`←0 and `last`←the previous owner.
- Read return: on a granted read, `rdatak`←`mem_rdata` and `rvalidk`←1 at the same edge. `rvalidk` is a single-cycle pulse. `rdatak` holds its value until the next read on that port.
- Writes produce no `rvalid`.
- With no select, `mem_addr` and `mem_wdata` hold their port-0 values and `mem_write`=0.
- `gnt0` and `gnt1` are never both 1 in the same cycle.

## Timing
- Reset values: state IDLE, `last`=1 (port 0 wins the first tie), `burst_cnt`=0, `gnt*`=0, `rvalid*`=0, `rdata*`=0, `owner`=0, `busy`=0, `mem_write`=0.
- Arbitration latency: a request seen in IDLE is granted in the next cycle.
- A held request from the owner is granted every cycle (throughput 1 access per cycle).
- Switch on release: one dead cycle, namely the cycle in which the owner's `req` is low.
- Forced switch: no dead cycle; the other port is granted in the cycle after the last owner grant.
- Read latency: data arrives one cycle after `gnt`. Memory writes commit at the edge ending the grant cycle.
- Requester rule: `req`, `we`, `addr` and `wdata` stay stable until sampled with `gnt`=1. The requester may change them in the cycle after `gnt`.
- Reset asserted mid-burst: all outputs go to reset values immediately, `mem_write` drops asynchronously, and any in-flight `rvalid` is lost.
- `MAX_BURST`=1: strict alternation whenever both ports request.

## Structure
- The shared package holds the state encoding (IDLE/OWN0/OWN1, 2 bits), the port index constants `PORT_CPU`=0 and `PORT_LDR`=1, and the `ADDR_W`/`WORD_W` defaults shared with the memory and processor.
- One natural sub-module, `rr_pick`: a combinational two-way round-robin selector taking `req0`, `req1`, `last` and producing the winner index.
- The FSM, burst counter, data mux and read-return registers stay in the top module.

## Test plan
- Reset then single read: memory[0x005]=0x1234; `req0`=1, `we0`=0, `addr0`=0x005. Required: `gnt0` in cycle 1, `rvalid0`=1 with `rdata0`=0x1234 in cycle 2, `busy`=1.
- Tie after reset: `req0`=`req1`=1 in the same cycle. Required: port 0 granted first; after `req0` drops, port 1 is granted (one dead cycle); the next tie goes to port 0 again (`last`=1).
- Burst cap: `MAX_BURST`=4, `req0` held continuously, `req1` raised. Required: exactly 4 `gnt0` pulses, then `gnt1` in the next cycle with no gap, `burst_cnt` back to 0.
- Write then read across ports: port 1 writes 0xBEEF to 0x0FF, then port 0 reads 0x0FF. Required: `mem_write`=1 for one cycle, then `rdata0`=0xBEEF.
- Reset mid-burst: `rst` pulled low during an OWN1 write cycle. Required: `mem_write`=0 immediately; after release, state is IDLE and all outputs are at reset values.
- Invariant checks over a random stress run: `gnt0`&`gnt1` never both 1; `mem_write` only when some `gnt` and its `we` are 1; every granted read yields exactly one `rvalid`.
